// File: rtl/key_press_emulator_if.sv
// Command channel of key_press_emulator: press request handshake with hold time and abort.
interface key_press_emulator_if #(
  parameter int HOLD_W = 20
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic [HOLD_W-1:0] cmd_hold;
  logic              cmd_abort;

  modport master (output cmd_valid, output cmd_hold, output cmd_abort, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_hold, input cmd_abort, output cmd_ready);
endinterface

// File: rtl/key_press_emulator.sv
// key_press_emulator: turns a press command into an idle-high, active-low key waveform.
// Define KEY_BOUNCE_EN to add LFSR-timed contact bounce on both edges (BNC_DN / BNC_UP).
module key_press_emulator #(
  parameter int                HOLD_W       = 20,
  parameter logic [HOLD_W-1:0] MIN_HOLD     = 20'd1000000,
  parameter logic [HOLD_W-1:0] GAP_CYCLES   = 20'd500000,
  parameter int                BOUNCE_EDGES = 4,
  parameter logic [7:0]        BOUNCE_MAX   = 8'd16
) (
  input  logic                      clk,
  input  logic                      n_rst,
  key_press_emulator_if.slave       cmd_bus,
  output logic                      key_out,
  output logic                      busy,
  output logic                      done
);

  localparam logic [HOLD_W-1:0] ONE      = {{(HOLD_W-1){1'b0}}, 1'b1};
  localparam logic [HOLD_W-1:0] GAP_LAST = GAP_CYCLES - ONE;
  localparam bit CFG_OK = (GAP_CYCLES != '0) && (BOUNCE_EDGES >= 2) &&
                          ((BOUNCE_EDGES % 2) == 0) && (BOUNCE_MAX != 8'd0);

  generate
    if (!CFG_OK) begin : g_bad_cfg
      $error("key_press_emulator: illegal GAP_CYCLES/BOUNCE_EDGES/BOUNCE_MAX");
    end
  endgenerate

`ifdef KEY_BOUNCE_EN
  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    PRESS  = 5'b00010,
    GUARD  = 5'b00100,
    BNC_DN = 5'b01000,
    BNC_UP = 5'b10000
  } state_t;

  localparam logic [7:0] BNC_EDGES = BOUNCE_EDGES[7:0];

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  logic [7:0] lfsr_r, lfsr_nx;
  logic [7:0] seg_r,  seg_nx;
  logic [7:0] edge_r, edge_nx;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    PRESS = 3'b010,
    GUARD = 3'b100
  } state_t;
`endif

  state_t            state_r, state_nx;
  logic [HOLD_W-1:0] cnt_r, cnt_nx;
  logic [HOLD_W-1:0] h_r, h_nx;
  logic              key_r, key_nx;
  logic              done_r, done_nx;
  logic [HOLD_W-1:0] cnt_inc_s;
  logic [HOLD_W-1:0] h_last_s;

  assign cnt_inc_s = (cnt_r == {HOLD_W{1'b1}}) ? cnt_r : cnt_r + ONE;
  assign h_last_s  = h_r - ONE;

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      h_r     <= '0;
      key_r   <= 1'b1;
      done_r  <= 1'b0;
`ifdef KEY_BOUNCE_EN
      lfsr_r  <= 8'hA5;
      seg_r   <= 8'd0;
      edge_r  <= 8'd0;
`endif
    end else begin
      state_r <= state_nx;
      cnt_r   <= cnt_nx;
      h_r     <= h_nx;
      key_r   <= key_nx;
      done_r  <= done_nx;
`ifdef KEY_BOUNCE_EN
      lfsr_r  <= lfsr_nx;
      seg_r   <= seg_nx;
      edge_r  <= edge_nx;
`endif
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_nx = state_r;
    cnt_nx   = cnt_r;
    h_nx     = h_r;
    key_nx   = key_r;
    done_nx  = 1'b0;
`ifdef KEY_BOUNCE_EN
    lfsr_nx  = lfsr_r;
    seg_nx   = seg_r;
    edge_nx  = edge_r;
`endif
    case (state_r)
      IDLE: begin
        if (cmd_bus.cmd_valid) begin
          h_nx   = (cmd_bus.cmd_hold < MIN_HOLD) ? MIN_HOLD : cmd_bus.cmd_hold;
          cnt_nx = '0;
          key_nx = 1'b0;
`ifdef KEY_BOUNCE_EN
          state_nx = BNC_DN;
          edge_nx  = 8'd0;
          seg_nx   = lfsr_r % BOUNCE_MAX;
          lfsr_nx  = lfsr_next(lfsr_r);
`else
          state_nx = PRESS;
`endif
        end else begin
          key_nx = 1'b1;
        end
      end
      PRESS: begin
        // Abort and hold expiry share one release path, so they can never double up
        if (cmd_bus.cmd_abort || (cnt_r == h_last_s)) begin
          key_nx = 1'b1;
          cnt_nx = '0;
`ifdef KEY_BOUNCE_EN
          state_nx = BNC_UP;
          edge_nx  = 8'd0;
          seg_nx   = lfsr_r % BOUNCE_MAX;
          lfsr_nx  = lfsr_next(lfsr_r);
`else
          state_nx = GUARD;
`endif
        end else begin
          key_nx = 1'b0;
          cnt_nx = cnt_inc_s;
        end
      end
      GUARD: begin
        key_nx = 1'b1;
        if (cnt_r == GAP_LAST) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          done_nx  = 1'b1;
        end else begin
          cnt_nx = cnt_inc_s;
        end
      end
`ifdef KEY_BOUNCE_EN
      // The initial edge heads to the target; BOUNCE_EDGES further toggles end there too
      BNC_DN: begin
        if (cmd_bus.cmd_abort) begin
          key_nx   = 1'b1;
          cnt_nx   = '0;
          state_nx = BNC_UP;
          edge_nx  = 8'd0;
          seg_nx   = lfsr_r % BOUNCE_MAX;
          lfsr_nx  = lfsr_next(lfsr_r);
        end else if (seg_r == 8'd0) begin
          key_nx  = ~key_r;
          edge_nx = edge_r + 8'd1;
          if ((edge_r + 8'd1) == BNC_EDGES) begin
            state_nx = PRESS;
            cnt_nx   = '0;
          end else begin
            seg_nx  = lfsr_r % BOUNCE_MAX;
            lfsr_nx = lfsr_next(lfsr_r);
          end
        end else begin
          seg_nx = seg_r - 8'd1;
        end
      end
      BNC_UP: begin
        if (seg_r == 8'd0) begin
          key_nx  = ~key_r;
          edge_nx = edge_r + 8'd1;
          if ((edge_r + 8'd1) == BNC_EDGES) begin
            state_nx = GUARD;
            cnt_nx   = '0;
          end else begin
            seg_nx  = lfsr_r % BOUNCE_MAX;
            lfsr_nx = lfsr_next(lfsr_r);
          end
        end else begin
          seg_nx = seg_r - 8'd1;
        end
      end
`endif
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        key_nx   = 1'b1;
      end
    endcase
  end

  assign cmd_bus.cmd_ready = (state_r == IDLE);
  assign busy              = (state_r != IDLE);
  assign key_out           = key_r;
  assign done              = done_r;

endmodule
